scan_decoder: RTL and testbench



---
 rtl/scan_decoder.sv | 150 +++++++++++++++
 tb/tb_scan_decoder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
// Registered active-low N-to-2^N strobe decoder with direct-select and auto-scan modes
// and break-before-make blanking. Optional line skipping via `define SCAN_DECODER_MASK_EN.
module scan_decoder #(
  parameter int SEL_W     = 2,
  parameter int DWELL     = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel_in,
`ifdef SCAN_DECODER_MASK_EN
  input  logic [(1<<SEL_W)-1:0]   mask,
`endif
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        cur_sel,
  output logic                    wrap
);

  localparam int N    = 1 << SEL_W;
  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int BL_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [BL_W-1:0] BLANK_LAST = (BLANK_CYC > 0) ? BL_W'(BLANK_CYC - 1) : '0;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [BL_W-1:0]   blank_q, blank_d;
  logic              wrap_q, wrap_d;
  logic              mode_q;
  logic [N-1:0]      out_q, out_d;

  logic [N-1:0]      skip;
`ifdef SCAN_DECODER_MASK_EN
  assign skip = mask;
`else
  assign skip = '0;
`endif

  // Next unmasked line strictly above cur_sel, wrapping; wraps when the search passes N-1.
  logic [SEL_W-1:0]  scan_next;
  logic              scan_wrap;
  logic              scan_found;

  always_comb begin
    scan_next  = cur_sel_q;
    scan_wrap  = 1'b0;
    scan_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!scan_found && !skip[SEL_W'(int'(cur_sel_q) + i)]) begin
        scan_found = 1'b1;
        scan_next  = SEL_W'(int'(cur_sel_q) + i);
        scan_wrap  = (int'(cur_sel_q) + i) >= N;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    dwell_d   = dwell_q;
    blank_d   = blank_q;
    wrap_d    = 1'b0;
    if (!en) begin
      state_d = IDLE;
      dwell_d = '0;
      blank_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!mode) cur_sel_d = sel_in;
          dwell_d = '0;
          blank_d = '0;
          if (BLANK_CYC == 0) state_d = DRIVE;
          else                state_d = BLANK;
        end
        BLANK: begin
          if (blank_q == BLANK_LAST) begin
            // A fully masked scan parks here until some line becomes eligible.
            if (!(mode && (&skip))) begin
              state_d = DRIVE;
              blank_d = '0;
            end
          end else begin
            blank_d = blank_q + BL_W'(1);
          end
        end
        DRIVE: begin
          if (!mode) begin
            dwell_d = '0;
            if (sel_in != cur_sel_q) begin
              cur_sel_d = sel_in;
              blank_d   = '0;
              if (BLANK_CYC == 0) state_d = DRIVE;
              else                state_d = BLANK;
            end
          end else if (!mode_q) begin
            dwell_d = '0;
          end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            blank_d = '0;
            if (scan_found) begin
              cur_sel_d = scan_next;
              wrap_d    = scan_wrap;
            end
            if (BLANK_CYC == 0) state_d = DRIVE;
            else                state_d = BLANK;
          end else begin
            dwell_d = dwell_q + DW_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Strobes are decoded from the registered state, so they trail cur_sel by one cycle.
  for (genvar gi = 0; gi < N; gi++) begin : g_line
    assign out_d[gi] = !((state_q == DRIVE) && (cur_sel_q == SEL_W'(gi)) && !skip[gi]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cur_sel_q <= '0;
      dwell_q   <= '0;
      blank_q   <= '0;
      wrap_q    <= 1'b0;
      mode_q    <= 1'b0;
      out_q     <= '1;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
      dwell_q   <= dwell_d;
      blank_q   <= blank_d;
      wrap_q    <= wrap_d;
      mode_q    <= mode;
      out_q     <= out_d;
    end
  end

  assign out     = out_q;
  assign cur_sel = cur_sel_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (default parameters); mask cases run when
// SCAN_DECODER_MASK_EN is defined.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       mode;
  logic [1:0] sel_in;
  logic [3:0] out;
  logic [1:0] cur_sel;
  logic       wrap;
`ifdef SCAN_DECODER_MASK_EN
  logic [3:0] mask_in;
`endif

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [3:0] pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  scan_decoder #(.SEL_W(2), .DWELL(4), .BLANK_CYC(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .sel_in  (sel_in),
`ifdef SCAN_DECODER_MASK_EN
    .mask    (mask_in),
`endif
    .out     (out),
    .cur_sel (cur_sel),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag, input logic [3:0] e_out, input logic [1:0] e_sel,
                      input logic e_wrap);
    @(posedge clk); #1;
    cyc++;
    $display("cyc %0d %s: out=%b cur_sel=%0d wrap=%b", cyc, tag, out, cur_sel, wrap);
    check({tag, " out"}, 32'(out), 32'(e_out));
    check({tag, " cur_sel"}, 32'(cur_sel), 32'(e_sel));
    check({tag, " wrap"}, 32'(wrap), 32'(e_wrap));
  endtask

  // One blank cycle then four drive cycles; cur_sel steps on the last one.
  task automatic scan_line(input int l);
    tick("scan blank", 4'hF, 2'(l), 1'b0);
    for (int i = 0; i < 4; i++)
      tick("scan drive", pat[l], (i == 3) ? 2'((l + 1) % 4) : 2'(l), (i == 3) && (l == 3));
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; mode = 1'b1; sel_in = 2'd0;
`ifdef SCAN_DECODER_MASK_EN
    mask_in = 4'b0000;
`endif
    tick("reset", 4'hF, 2'd0, 1'b0);
    tick("reset", 4'hF, 2'd0, 1'b0);
    reset = 1'b0;
    tick("start", 4'hF, 2'd0, 1'b0);

    for (int r = 0; r < 2; r++)
      for (int l = 0; l < 4; l++)
        scan_line(l);

    // Enable dropped two drive cycles into line 2.
    scan_line(0);
    scan_line(1);
    tick("line2 blank", 4'hF, 2'd2, 1'b0);
    tick("line2 drive", 4'b1011, 2'd2, 1'b0);
    tick("line2 drive", 4'b1011, 2'd2, 1'b0);
    en = 1'b0;
    tick("en low", 4'b1011, 2'd2, 1'b0);
    tick("en low", 4'hF, 2'd2, 1'b0);
    tick("en low", 4'hF, 2'd2, 1'b0);
    en = 1'b1;
    tick("re-enable", 4'hF, 2'd2, 1'b0);
    scan_line(2);
    tick("line3 blank", 4'hF, 2'd3, 1'b0);

    // Direct mode: reselect, hold, then 2 -> 3.
    mode = 1'b0; sel_in = 2'd2;
    tick("direct sel2", 4'b0111, 2'd2, 1'b0);
    tick("direct blank", 4'hF, 2'd2, 1'b0);
    tick("direct hold", 4'b1011, 2'd2, 1'b0);
    tick("direct hold", 4'b1011, 2'd2, 1'b0);
    sel_in = 2'd3;
    tick("direct k", 4'b1011, 2'd3, 1'b0);
    tick("direct k+1", 4'hF, 2'd3, 1'b0);
    tick("direct k+2", 4'b0111, 2'd3, 1'b0);

    // sel_in changed while blanking is ignored until DRIVE.
    sel_in = 2'd0;
    tick("to sel0", 4'b0111, 2'd0, 1'b0);
    sel_in = 2'd1;
    tick("blank ignore", 4'hF, 2'd0, 1'b0);
    tick("reselect", 4'b1110, 2'd1, 1'b0);
    tick("sel1 blank", 4'hF, 2'd1, 1'b0);
    tick("sel1 drive", 4'b1101, 2'd1, 1'b0);

    // Switch to scan while driving: full dwell restarts on line 1.
    mode = 1'b1;
    for (int i = 0; i < 4; i++)
      tick("to scan", 4'b1101, 2'd1, 1'b0);
    tick("to scan adv", 4'b1101, 2'd2, 1'b0);
    tick("to scan blank", 4'hF, 2'd2, 1'b0);

`ifdef SCAN_DECODER_MASK_EN
    begin
      logic seen1, seen3, seen_wrap;
      seen1 = 1'b0; seen3 = 1'b0; seen_wrap = 1'b0;
      reset = 1'b1; mask_in = 4'b0101;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 48; i++) begin
        @(posedge clk); #1;
        check("mask skip l0", 32'(out[0]), 32'd1);
        check("mask skip l2", 32'(out[2]), 32'd1);
        if (out == 4'b1101) seen1 = 1'b1;
        if (out == 4'b0111) seen3 = 1'b1;
        if (wrap) seen_wrap = 1'b1;
      end
      check("mask saw l1", 32'(seen1), 32'd1);
      check("mask saw l3", 32'(seen3), 32'd1);
      check("mask saw wrap", 32'(seen_wrap), 32'd1);

      reset = 1'b1; mask_in = 4'b1111;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 24; i++) begin
        @(posedge clk); #1;
        check("all masked out", 32'(out), 32'hF);
        check("all masked wrap", 32'(wrap), 32'd0);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
